keyword_nest_checker: RTL and testbench
=======================================

Name: keyword_nest_checker

Overview:
Streaming ASCII checker. Consumes one character per valid cycle, splits the stream into words, and tracks nesting of begin/end and, optionally, case/endcase keyword pairs on a parametrised type stack. Reports balance, nesting depth, peak depth and the first structural error. Sits beside the character-stream front end, next to the existing block-balance checker, and adds mixed-pair matching, stream framing and error classification.

Parameters:
STACK_DEPTH, 16, maximum nesting entries (>=1); DW = clog2(STACK_DEPTH+1) is a localparam
ENABLE_CASE, 1, 1 = case/endcase are keywords; 0 = they are ordinary words

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
clear  in  1  synchronous clear; same effect as reset; has priority over in_valid
in_valid  in  1  in_data is accepted this cycle; the block is always ready
in_data  in  8  ASCII character
in_last  in  1  with in_valid: this is the final character of the stream
balanced  out  1  depth==0 and no error
error  out  1  sticky error flag
error_code  out  2  0 none, 1 underflow, 2 mismatch, 3 overflow; records the first error only
depth  out  DW  current stack occupancy
max_depth  out  DW  peak depth since reset/clear
done  out  1  one-cycle pulse after the in_last character has been processed

Behaviour:
- Reset/clear values: depth=0, max_depth=0, error=0, error_code=0, balanced=1, done=0. Word buffer and stack are emptied.
- Delimiters: 0x20, 0x09, 0x0A, 0x0D. Any other byte is a word character.
- Start of stream, and the cycle after in_last, count as a word boundary. No leading space is needed.
- Word buffer holds up to 7 characters plus a length-overflow flag. A word longer than 7 characters never matches a keyword.
- Keyword compare is case-insensitive: fold A-Z to a-z on capture.
- A word completes when either:
  - a delimiter is accepted, or
  - a non-delimiter is accepted with in_last=1; that character is included in the word.
- An empty word (consecutive delimiters) is a no-op.
- Classification of a completed word:
  - "begin": push type B.
  - "case": push type C (ENABLE_CASE=1 only).
  - "end": pop, expecting B.
  - "endcase": pop, expecting C (ENABLE_CASE=1 only).
  - Anything else: no effect.
- Error checks, first match wins:
  - Pop on empty stack -> underflow (code 1).
  - Pop whose top type differs from the expected type -> mismatch (code 2).
  - Push with depth==STACK_DEPTH -> overflow (code 3).
- On an error: error=1, error_code latched, stack and depth frozen. All later words are ignored until reset/clear. Characters are still accepted; done still pulses.
- Latency: the effect of the completing character appears on depth, max_depth, balanced and error in the cycle after it is accepted (registered outputs).
- max_depth updates in the same cycle as a push: max_depth = max(max_depth, new depth).
- After in_last: the word buffer is emptied. done=1 for exactly one cycle, aligned with the final output update. depth and stack persist; only clear/reset empties them.
- in_valid=0: no state change. in_data and in_last are ignored.
- Reset asserted mid-word or mid-stream: immediate return to reset values. The partial word is discarded.
- clear and in_valid together: the character is dropped and the clear takes effect.
- Stack: STACK_DEPTH x 1-bit type register array with a DW-bit pointer. No wrap-around: overflow is an error, never a wrap.

Test Plan:
- Stream "begin end" with in_last on the final 'd' -> depth 1 then 0; balanced=1, max_depth=1, done pulses once, error_code=0.
- Stream "BEGIN case x EndCase End" (ENABLE_CASE=1) -> depth goes 1,2,1,0; max_depth=2; balanced=1.
- Stream "begin endcase" -> error=1, error_code=2, depth stays 1. A following " end" leaves depth=1 and code=2.
- Stream "end begin" -> error_code=1 after "end", depth=0, balanced=0. The later "begin" is ignored.
- STACK_DEPTH=4, stream of five "begin " -> depth=4, error_code=3 after the fifth; max_depth=4.
- Edge cases:
  - "beginx ends  " -> no change, balanced=1.
  - ENABLE_CASE=0 with "case" -> no change.
  - "begin" ending with in_last -> depth=1, balanced=0.
  - reset pulse mid-"beg" -> all outputs return to reset values.

Source files
------------

// File: rtl/keyword_nest_checker.sv
// keyword_nest_checker
// Streaming ASCII checker. Consumes one character per valid cycle, splits the
// stream into words on whitespace and tracks begin/end (and optionally
// case/endcase) nesting on a type stack. Reports balance, depth, peak depth and
// the first structural error.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   clear      in   synchronous clear, same effect as reset, beats in_valid
//   in_valid   in   in_data is accepted this cycle (always ready)
//   in_data    in   8-bit ASCII character
//   in_last    in   with in_valid: final character of the stream
//   balanced   out  depth == 0 and no error
//   error      out  sticky error flag
//   error_code out  0 none, 1 underflow, 2 mismatch, 3 overflow (first only)
//   depth      out  current stack occupancy
//   max_depth  out  peak depth since reset/clear
//   done       out  one-cycle pulse after the in_last character is processed
module keyword_nest_checker #(
    parameter int unsigned STACK_DEPTH = 16,
    parameter int unsigned ENABLE_CASE = 1,
    localparam int unsigned DW = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          balanced,
    output logic          error,
    output logic [1:0]    error_code,
    output logic [DW-1:0] depth,
    output logic [DW-1:0] max_depth,
    output logic          done
);

    localparam int unsigned WORD_MAX = 7;
    localparam int unsigned LW       = 3;
    localparam int unsigned SW       = STACK_DEPTH;

    typedef logic [WORD_MAX-1:0][7:0] word_t;

    localparam logic [1:0] CODE_NONE      = 2'd0;
    localparam logic [1:0] CODE_UNDERFLOW = 2'd1;
    localparam logic [1:0] CODE_MISMATCH  = 2'd2;
    localparam logic [1:0] CODE_OVERFLOW  = 2'd3;

    // Stack entry type: 0 = begin, 1 = case
    localparam logic T_BEGIN = 1'b0;
    localparam logic T_CASE  = 1'b1;

    // Keywords stored with the first character in byte 0, unused bytes zero
    localparam word_t KW_BEGIN   = {16'h0000, "n", "i", "g", "e", "b"};
    localparam word_t KW_END     = {32'h0000_0000, "d", "n", "e"};
    localparam word_t KW_CASE    = {24'h00_0000, "e", "s", "a", "c"};
    localparam word_t KW_ENDCASE = {"e", "s", "a", "c", "d", "n", "e"};

    localparam logic CASE_ON = (ENABLE_CASE != 0);

    // Word buffer
    word_t          chars_q, chars_d;
    logic [LW-1:0]  len_q, len_d;
    logic           long_q, long_d;

    // Type stack and status
    logic [SW-1:0]  stack_q, stack_d;
    logic [DW-1:0]  depth_q, depth_d;
    logic [DW-1:0]  max_q, max_d;
    logic           err_q, err_d;
    logic [1:0]     code_q, code_d;
    logic           bal_q, bal_d;
    logic           done_q, done_d;

    // Combinational helpers
    logic [7:0]     ch;
    logic           is_delim;
    word_t          app_chars;
    logic [LW-1:0]  app_len;
    logic           app_long;
    word_t          w_chars;
    logic [LW-1:0]  w_len;
    logic           w_long;
    logic           word_done;
    logic           kw_begin, kw_end, kw_case, kw_endcase;
    logic           do_push, do_pop;
    logic           push_type, pop_type;
    logic [SW-1:0]  top_shift;
    logic           top_type;

    // Fold A-Z to a-z so keyword compare is case-insensitive
    function automatic logic [7:0] fold_lower(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A) begin
            return c | 8'h20;
        end
        return c;
    endfunction

    // Next-state logic
    always_comb begin
        chars_d = chars_q;
        len_d   = len_q;
        long_d  = long_q;
        stack_d = stack_q;
        depth_d = depth_q;
        max_d   = max_q;
        err_d   = err_q;
        code_d  = code_q;
        done_d  = 1'b0;

        ch       = fold_lower(in_data);
        is_delim = (in_data == 8'h20) || (in_data == 8'h09) ||
                   (in_data == 8'h0A) || (in_data == 8'h0D);

        // Buffer with the current character appended; an eighth character only
        // sets the length-overflow flag so the word can never match
        app_chars = chars_q;
        app_len   = len_q;
        app_long  = long_q;
        if (!is_delim) begin
            if (len_q == LW'(WORD_MAX)) begin
                app_long = 1'b1;
            end else begin
                app_chars[len_q] = ch;
                app_len          = len_q + LW'(1);
            end
        end

        // A delimiter closes the buffered word; a last non-delimiter closes
        // the word that includes it
        word_done = in_valid && (is_delim || in_last);
        w_chars   = is_delim ? chars_q : app_chars;
        w_len     = is_delim ? len_q   : app_len;
        w_long    = is_delim ? long_q  : app_long;

        kw_begin   = !w_long && (w_len == LW'(5)) && (w_chars == KW_BEGIN);
        kw_end     = !w_long && (w_len == LW'(3)) && (w_chars == KW_END);
        kw_case    = CASE_ON && !w_long && (w_len == LW'(4)) && (w_chars == KW_CASE);
        kw_endcase = CASE_ON && !w_long && (w_len == LW'(7)) && (w_chars == KW_ENDCASE);

        do_push   = kw_begin || kw_case;
        do_pop    = kw_end || kw_endcase;
        push_type = kw_case ? T_CASE : T_BEGIN;
        pop_type  = kw_endcase ? T_CASE : T_BEGIN;

        // Type at the top of the stack (only meaningful when depth > 0)
        top_shift = stack_q >> (depth_q - DW'(1));
        top_type  = top_shift[0];

        if (in_valid) begin
            done_d = in_last;
            if (word_done) begin
                chars_d = '0;
                len_d   = '0;
                long_d  = 1'b0;
            end else begin
                chars_d = app_chars;
                len_d   = app_len;
                long_d  = app_long;
            end
        end

        // Stack update; frozen once an error has been seen
        if (word_done && !err_q) begin
            if (do_pop) begin
                if (depth_q == '0) begin
                    err_d  = 1'b1;
                    code_d = CODE_UNDERFLOW;
                end else if (top_type != pop_type) begin
                    err_d  = 1'b1;
                    code_d = CODE_MISMATCH;
                end else begin
                    depth_d = depth_q - DW'(1);
                end
            end else if (do_push) begin
                if (depth_q == DW'(STACK_DEPTH)) begin
                    err_d  = 1'b1;
                    code_d = CODE_OVERFLOW;
                end else begin
                    stack_d = (stack_q & ~(SW'(1'b1) << depth_q)) |
                              (SW'(push_type) << depth_q);
                    depth_d = depth_q + DW'(1);
                    if (depth_d > max_q) begin
                        max_d = depth_d;
                    end
                end
            end
        end

        bal_d = (depth_d == '0) && !err_d;
    end

    // State registers; clear has priority over any accepted character
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chars_q <= '0;
            len_q   <= '0;
            long_q  <= 1'b0;
            stack_q <= '0;
            depth_q <= '0;
            max_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= CODE_NONE;
            bal_q   <= 1'b1;
            done_q  <= 1'b0;
        end else if (clear) begin
            chars_q <= '0;
            len_q   <= '0;
            long_q  <= 1'b0;
            stack_q <= '0;
            depth_q <= '0;
            max_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= CODE_NONE;
            bal_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            chars_q <= chars_d;
            len_q   <= len_d;
            long_q  <= long_d;
            stack_q <= stack_d;
            depth_q <= depth_d;
            max_q   <= max_d;
            err_q   <= err_d;
            code_q  <= code_d;
            bal_q   <= bal_d;
            done_q  <= done_d;
        end
    end

    assign balanced   = bal_q;
    assign error      = err_q;
    assign error_code = code_q;
    assign depth      = depth_q;
    assign max_depth  = max_q;
    assign done       = done_q;

endmodule

// File: tb/tb_keyword_nest_checker.sv
// tb_keyword_nest_checker
// Directed bench: three checker instances (default, STACK_DEPTH=4,
// ENABLE_CASE=0) share one character stream; expected values are hand-derived.
module tb_keyword_nest_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;

    logic       a_bal, a_err, a_done;
    logic [1:0] a_code;
    logic [4:0] a_depth, a_max;

    logic       b_bal, b_err, b_done;
    logic [1:0] b_code;
    logic [2:0] b_depth, b_max;

    logic       c_bal, c_err, c_done;
    logic [1:0] c_code;
    logic [4:0] c_depth, c_max;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    keyword_nest_checker #(.STACK_DEPTH(16), .ENABLE_CASE(1)) u_a (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .balanced(a_bal), .error(a_err),
        .error_code(a_code), .depth(a_depth), .max_depth(a_max), .done(a_done)
    );

    keyword_nest_checker #(.STACK_DEPTH(4), .ENABLE_CASE(1)) u_b (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .balanced(b_bal), .error(b_err),
        .error_code(b_code), .depth(b_depth), .max_depth(b_max), .done(b_done)
    );

    keyword_nest_checker #(.STACK_DEPTH(16), .ENABLE_CASE(0)) u_c (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .balanced(c_bal), .error(c_err),
        .error_code(c_code), .depth(c_depth), .max_depth(c_max), .done(c_done)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full status of the default instance
    task automatic check_a(input string tag, input int dep, input int mx,
                           input int er, input int cd, input int bl);
        check_eq({tag, ".depth"},    int'(a_depth), dep);
        check_eq({tag, ".max"},      int'(a_max),   mx);
        check_eq({tag, ".error"},    int'(a_err),   er);
        check_eq({tag, ".code"},     int'(a_code),  cd);
        check_eq({tag, ".balanced"}, int'(a_bal),   bl);
    endtask

    // Drive a string one character per cycle; returns one negedge after the
    // last character so registered outputs reflect it
    task automatic send_str(input string s, input bit last_on_end);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = s[i];
            in_last  = last_on_end && (i == s.len() - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check_a("rst", 0, 0, 0, 0, 1);
        check_eq("rst.done", int'(a_done), 0);

        // begin end
        send_str("begin ", 1'b0);
        check_a("be1", 1, 1, 0, 0, 0);
        send_str("end", 1'b1);
        check_a("be2", 0, 1, 0, 0, 1);
        check_eq("be2.done", int'(a_done), 1);
        @(negedge clk);
        check_eq("be2.done_low", int'(a_done), 0);

        // Mixed pairs, case-insensitive
        do_clear();
        check_eq("clr.max", int'(a_max), 0);
        send_str("BEGIN ", 1'b0);
        check_eq("mix1.depth", int'(a_depth), 1);
        send_str("case ", 1'b0);
        check_eq("mix2.depth", int'(a_depth), 2);
        check_eq("mix2.nc_depth", int'(c_depth), 1);
        send_str("x ", 1'b0);
        check_eq("mix3.depth", int'(a_depth), 2);
        send_str("EndCase ", 1'b0);
        check_eq("mix4.depth", int'(a_depth), 1);
        check_eq("mix4.nc_depth", int'(c_depth), 1);
        send_str("End", 1'b1);
        check_a("mix5", 0, 2, 0, 0, 1);
        check_eq("mix5.nc_depth", int'(c_depth), 0);
        check_eq("mix5.nc_max", int'(c_max), 1);
        check_eq("mix5.nc_bal", int'(c_bal), 1);

        // Mismatch
        do_clear();
        send_str("begin endcase ", 1'b0);
        check_a("mm1", 1, 1, 1, 2, 0);
        check_eq("mm1.nc_err", int'(c_err), 0);
        send_str(" end", 1'b1);
        check_a("mm2", 1, 1, 1, 2, 0);
        check_eq("mm2.done", int'(a_done), 1);
        check_eq("mm2.nc_depth", int'(c_depth), 0);

        // Underflow
        do_clear();
        send_str("end ", 1'b0);
        check_a("uf1", 0, 0, 1, 1, 0);
        send_str("begin", 1'b1);
        check_a("uf2", 0, 0, 1, 1, 0);

        // Overflow on the 4-deep instance
        do_clear();
        send_str("begin begin begin begin ", 1'b0);
        check_eq("of1.depth", int'(b_depth), 4);
        check_eq("of1.code", int'(b_code), 0);
        send_str("begin ", 1'b0);
        check_eq("of2.depth", int'(b_depth), 4);
        check_eq("of2.err", int'(b_err), 1);
        check_eq("of2.code", int'(b_code), 3);
        check_eq("of2.max", int'(b_max), 4);
        check_eq("of2.a_depth", int'(a_depth), 5);
        check_eq("of2.a_max", int'(a_max), 5);

        // Non-keywords, long words, other delimiters
        do_clear();
        send_str("beginx ends  ", 1'b0);
        check_a("nk1", 0, 0, 0, 0, 1);
        send_str("begin beginend endcasex end ", 1'b0);
        check_a("nk2", 0, 1, 0, 0, 1);
        send_str("begin\tCASE\nENDCASE\rend ", 1'b0);
        check_a("nk3", 0, 2, 0, 0, 1);

        // in_last ends a word and the next cycle is a fresh boundary
        do_clear();
        send_str("begin", 1'b1);
        check_a("lst1", 1, 1, 0, 0, 0);
        check_eq("lst1.done", int'(a_done), 1);
        send_str("end", 1'b1);
        check_a("lst2", 0, 1, 0, 0, 1);

        // Reset mid-word discards the partial word
        do_clear();
        send_str("begin ", 1'b0);
        send_str("beg", 1'b0);
        reset = 1'b1;
        #2;
        check_a("rmw", 0, 0, 0, 0, 1);
        check_eq("rmw.done", int'(a_done), 0);
        @(negedge clk);
        reset = 1'b0;
        send_str("in ", 1'b0);
        check_a("rmw2", 0, 0, 0, 0, 1);

        // clear together with in_valid drops the character and the buffer
        send_str("begin", 1'b0);
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h20;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        check_eq("cv1.depth", int'(a_depth), 0);
        send_str(" ", 1'b0);
        check_a("cv2", 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
